// File: rtl/batalha_pkg.sv
// Shared types for the Batalha Naval placement logic: FSM state encoding, ship types and fleet quotas.
package batalha_pkg;

    // State codes double as the one-hot estado indicator; DONE reads as all zeros.
    typedef enum logic [5:0] {
        ST_DONE = 6'b000000,
        ST_DIR  = 6'b000001,
        ST_ORI  = 6'b000010,
        ST_X    = 6'b000100,
        ST_Y    = 6'b001000,
        ST_VAL  = 6'b010000,
        ST_STO  = 6'b100000
    } state_e;

    typedef enum logic [2:0] {
        T_SUB = 3'd0,
        T_CRU = 3'd1,
        T_SEA = 3'd2,
        T_BAT = 3'd3,
        T_CAR = 3'd4
    } tipo_e;

    localparam int NUM_TYPES = 5;

    localparam logic [2:0] QUOTA [0:NUM_TYPES-1] = '{3'd5, 3'd2, 3'd2, 3'd1, 3'd1};

    function automatic logic [2:0] next_ori(input logic [2:0] ori);
        return (ori == 3'd4) ? 3'd0 : ori + 3'd1;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Button synchroniser: two flops into the clock domain, then a one-cycle pulse on each rising edge.
// Pulse appears in the cycle after the second sync flop captures the rise; no backpressure.
module btn_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_pulse = r_sync2 & ~r_prev;

endmodule

// File: rtl/posiciona_frota.sv
// Fleet placement controller: per ship, choose direction/orientation/X/Y, validate over req/ack, strobe store.
// PLACE_VAL_TIMEOUT_EN: a missing validator ack after VAL_TIMEOUT cycles counts as a conflict and sets timeout_err.
module posiciona_frota #(
    parameter int BOARD_N     = 8,
    parameter int COORD_W     = 4,
    parameter int NUM_PLAYERS = 2,
    parameter int PLY_W       = 1,
    parameter int VAL_TIMEOUT = 255
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_enter,
    input  logic               i_select,
    input  logic               i_mode,
    input  logic [BOARD_N-1:0] i_sw,
    input  logic               i_val_ack,
    input  logic               i_val_conflict,
    output logic               o_val_req,
    output logic               o_wr_en,
    output logic [2:0]         o_tipo,
    output logic [PLY_W-1:0]   o_jogador,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic               o_direcao,
    output logic [2:0]         o_orientacao,
    output logic               o_ready,
    output logic [5:0]         o_estado,
    output logic               o_coord_err,
    output logic               o_timeout_err
);

    import batalha_pkg::*;

    logic w_enter;
    logic w_select;

    btn_edge u_enter (
        .i_clk   (i_clk),
        .i_rst   (i_reset),
        .i_btn   (i_enter),
        .o_pulse (w_enter)
    );

    btn_edge u_select (
        .i_clk   (i_clk),
        .i_rst   (i_reset),
        .i_btn   (i_select),
        .o_pulse (w_select)
    );

    state_e             r_state;
    logic               r_dir;
    logic [2:0]         r_ori;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic [2:0]         r_tipo;
    logic [2:0]         r_cnt;
    logic [PLY_W-1:0]   r_jog;
    logic               r_mode;
    logic               r_val_req;
    logic               r_wr_en;
    logic               r_ready;
    logic               r_coord_err;

`ifdef PLACE_VAL_TIMEOUT_EN
    localparam int TO_W = $clog2(VAL_TIMEOUT + 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = |VAL_TIMEOUT;
`endif

    logic [COORD_W-1:0] w_coord;
    logic               w_sw_ok;
    logic [2:0]         w_cnt_nxt;
    logic [PLY_W-1:0]   w_last_ply;
    logic               w_start;

    // sw[BOARD_N-1] is coordinate 1, sw[0] is coordinate BOARD_N.
    always_comb begin
        w_coord = '0;
        for (int i = 0; i < BOARD_N; i++) begin
            if (i_sw[i]) begin
                w_coord = COORD_W'(BOARD_N - i);
            end
        end
    end

    assign w_sw_ok    = $onehot(i_sw);
    assign w_cnt_nxt  = r_cnt + 3'd1;
    assign w_last_ply = r_mode ? PLY_W'(NUM_PLAYERS - 1) : '0;
    assign w_start    = (r_jog == '0) && (r_tipo == T_SUB) && (r_cnt == 3'd0);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_DIR;
            r_dir       <= 1'b0;
            r_ori       <= 3'd0;
            r_x         <= '0;
            r_y         <= '0;
            r_tipo      <= T_SUB;
            r_cnt       <= 3'd0;
            r_jog       <= '0;
            r_mode      <= 1'b0;
            r_val_req   <= 1'b0;
            r_wr_en     <= 1'b0;
            r_ready     <= 1'b0;
            r_coord_err <= 1'b0;
`ifdef PLACE_VAL_TIMEOUT_EN
            r_to_cnt    <= '0;
            r_timeout   <= 1'b0;
`endif
        end else begin
            r_wr_en     <= 1'b0;
            r_coord_err <= 1'b0;
            if (i_enable) begin
                case (r_state)
                    ST_DIR: begin
                        // Game mode is only picked up before the first ship of the game.
                        if (w_start) begin
                            r_mode <= i_mode;
                        end
                        if (w_enter) begin
                            r_state <= ST_ORI;
                        end else if (w_select) begin
                            r_dir <= ~r_dir;
                        end
                    end
                    ST_ORI: begin
                        if (w_enter) begin
                            r_state <= ST_X;
                        end else if (w_select) begin
                            r_ori <= next_ori(r_ori);
                        end
                    end
                    ST_X: begin
                        if (w_enter) begin
                            if (w_sw_ok) begin
                                r_x     <= w_coord;
                                r_state <= ST_Y;
                            end else begin
                                r_coord_err <= 1'b1;
                            end
                        end
                    end
                    ST_Y: begin
                        if (w_enter) begin
                            if (w_sw_ok) begin
                                r_y     <= w_coord;
                                r_state <= ST_VAL;
                            end else begin
                                r_coord_err <= 1'b1;
                            end
                        end
                    end
                    ST_VAL: begin
                        // First VAL cycle raises the request; acks only count once it is up.
                        if (!r_val_req) begin
                            r_val_req <= 1'b1;
`ifdef PLACE_VAL_TIMEOUT_EN
                            r_to_cnt  <= '0;
`endif
                        end else if (i_val_ack) begin
                            r_val_req <= 1'b0;
                            if (i_val_conflict) begin
                                r_state <= ST_X;
                            end else begin
                                r_state <= ST_STO;
                                r_wr_en <= 1'b1;
                            end
`ifdef PLACE_VAL_TIMEOUT_EN
                        end else if (r_to_cnt == TO_W'(VAL_TIMEOUT - 1)) begin
                            r_val_req <= 1'b0;
                            r_timeout <= 1'b1;
                            r_state   <= ST_X;
                        end else begin
                            r_to_cnt <= r_to_cnt + TO_W'(1);
`endif
                        end
                    end
                    ST_STO: begin
                        r_state <= ST_DIR;
                        r_dir   <= 1'b0;
                        r_ori   <= 3'd0;
                        if (w_cnt_nxt == QUOTA[r_tipo]) begin
                            r_cnt <= 3'd0;
                            if (r_tipo == T_CAR) begin
                                r_tipo <= T_SUB;
                                if (r_jog == w_last_ply) begin
                                    r_state <= ST_DONE;
                                    r_ready <= 1'b1;
                                end else begin
                                    r_jog <= r_jog + PLY_W'(1);
                                end
                            end else begin
                                r_tipo <= r_tipo + 3'd1;
                            end
                        end else begin
                            r_cnt <= w_cnt_nxt;
                        end
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

    assign o_val_req    = r_val_req;
    assign o_wr_en      = r_wr_en;
    assign o_tipo       = r_tipo;
    assign o_jogador    = r_jog;
    assign o_x          = r_x;
    assign o_y          = r_y;
    assign o_direcao    = r_dir;
    assign o_orientacao = r_ori;
    assign o_ready      = r_ready;
    assign o_estado     = r_state;
    assign o_coord_err  = r_coord_err;
`ifdef PLACE_VAL_TIMEOUT_EN
    assign o_timeout_err = r_timeout;
`else
    assign o_timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_posiciona_frota.sv
// Randomised placement bench: each accepted ship pushes its expected store record; a monitor pops on wr_en.
module tb_posiciona_frota;

    localparam int BOARD_N     = 8;
    localparam int COORD_W     = 4;
    localparam int NUM_PLAYERS = 2;
    localparam int PLY_W       = 1;
    localparam int FLEET_SZ    = 11;

    logic               clk = 1'b0;
    logic               reset, enable, enter, select, mode, val_ack, val_conflict;
    logic [BOARD_N-1:0] sw;
    logic               o_val_req, o_wr_en, o_direcao, o_ready, o_coord_err, o_timeout_err;
    logic [2:0]         o_tipo, o_orientacao;
    logic [PLY_W-1:0]   o_jogador;
    logic [COORD_W-1:0] o_x, o_y;
    logic [5:0]         o_estado;

    posiciona_frota #(
        .BOARD_N(BOARD_N), .COORD_W(COORD_W), .NUM_PLAYERS(NUM_PLAYERS),
        .PLY_W(PLY_W), .VAL_TIMEOUT(255)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_enter(enter),
        .i_select(select), .i_mode(mode), .i_sw(sw), .i_val_ack(val_ack),
        .i_val_conflict(val_conflict), .o_val_req(o_val_req), .o_wr_en(o_wr_en),
        .o_tipo(o_tipo), .o_jogador(o_jogador), .o_x(o_x), .o_y(o_y),
        .o_direcao(o_direcao), .o_orientacao(o_orientacao), .o_ready(o_ready),
        .o_estado(o_estado), .o_coord_err(o_coord_err), .o_timeout_err(o_timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic [2:0] tipo;
        logic       jog;
        logic       dir;
        logic [2:0] ori;
    } rec_t;

    rec_t exp_q[$];
    rec_t mon_e;
    int   fleet[$];
    int   checks   = 0;
    int   failures = 0;
    int   wr_seen  = 0;
    int   cerr_seen = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (o_coord_err) cerr_seen++;
        if (o_wr_en) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wr_unexpected actual=1 expected=0");
            end else begin
                mon_e = exp_q.pop_front();
                check("sto_x", o_x, mon_e.x);
                check("sto_y", o_y, mon_e.y);
                check("sto_tipo", o_tipo, mon_e.tipo);
                check("sto_jogador", o_jogador, mon_e.jog);
                check("sto_direcao", o_direcao, mon_e.dir);
                check("sto_orientacao", o_orientacao, mon_e.ori);
                check("sto_estado", o_estado, 32);
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_enter();
        enter = 1'b1; tick(3); enter = 1'b0; tick(4);
    endtask

    task automatic press_select();
        select = 1'b1; tick(3); select = 1'b0; tick(4);
    endtask

    task automatic enter_coords(input int xb, input int yb);
        logic [BOARD_N-1:0] v;
        v = '0; v[xb] = 1'b1; sw = v; press_enter();
        v = '0; v[yb] = 1'b1; sw = v; press_enter();
        sw = '0;
    endtask

    task automatic do_ack(input bit c);
        int n = 0;
        while (!o_val_req && n < 20) begin tick(1); n++; end
        check("val_req_up", o_val_req, 1);
        tick($urandom_range(0, 3));
        val_ack = 1'b1; val_conflict = c;
        tick(1);
        val_ack = 1'b0; val_conflict = 1'b0;
    endtask

    task automatic place(input int k, input int xb, input int yb, input int nd, input int no,
                         input bit conflict_first, input bit bad_x, input bit both, input bit long_wait);
        rec_t e;
        int   w0, c0, n;
        check("dir_entry_state", o_estado, 1);
        check("dir_entry_direcao", o_direcao, 0);
        check("dir_entry_orientacao", o_orientacao, 0);
        repeat (nd) press_select();
        check("direcao_toggle", o_direcao, nd % 2);
        if (both) begin
            enter = 1'b1; select = 1'b1; tick(3);
            enter = 1'b0; select = 1'b0; tick(4);
            check("both_to_ori", o_estado, 2);
            check("both_dir_kept", o_direcao, nd % 2);
        end else begin
            press_enter();
        end
        repeat (no) press_select();
        check("orientacao_wrap", o_orientacao, no % 5);
        press_enter();
        if (bad_x) begin
            sw = 8'b00110000;
            c0 = cerr_seen;
            press_enter();
            check("coord_err_pulse", cerr_seen - c0, 1);
            check("coord_err_stay_x", o_estado, 4);
        end
        enter_coords(xb, yb);
        if (conflict_first) begin
            w0 = wr_seen;
            do_ack(1'b1);
            tick(2);
            check("conflict_to_x", o_estado, 4);
            check("conflict_no_wr", wr_seen, w0);
            check("conflict_dir_kept", o_direcao, nd % 2);
            enter_coords(xb, yb);
        end
        if (long_wait) begin
            tick(300);
`ifdef PLACE_VAL_TIMEOUT_EN
            check("timeout_err_set", o_timeout_err, 1);
            check("timeout_to_x", o_estado, 4);
            check("timeout_req_low", o_val_req, 0);
            enter_coords(xb, yb);
`else
            check("no_timeout_state", o_estado, 16);
            check("no_timeout_req", o_val_req, 1);
            check("no_timeout_err", o_timeout_err, 0);
`endif
        end
        e.x    = 4'(BOARD_N - xb);
        e.y    = 4'(BOARD_N - yb);
        e.tipo = 3'(fleet[k % FLEET_SZ]);
        e.jog  = 1'(k / FLEET_SZ);
        e.dir  = 1'(nd % 2);
        e.ori  = 3'(no % 5);
        exp_q.push_back(e);
        w0 = wr_seen;
        do_ack(1'b0);
        n = 0;
        while (wr_seen == w0 && n < 20) begin tick(1); n++; end
        check("wr_pulse", wr_seen - w0, 1);
        tick(2);
    endtask

    initial begin
        int quota[5] = '{5, 2, 2, 1, 1};
        int w0;
        for (int t = 0; t < 5; t++)
            for (int q = 0; q < quota[t]; q++) fleet.push_back(t);

        reset = 1'b1; enable = 1'b1; enter = 1'b0; select = 1'b0; mode = 1'b0;
        val_ack = 1'b0; val_conflict = 1'b0; sw = '0;
        tick(3);
        reset = 1'b0;
        tick(2);
        check("rst_estado", o_estado, 1);
        check("rst_val_req", o_val_req, 0);
        check("rst_wr_en", o_wr_en, 0);
        check("rst_tipo", o_tipo, 0);
        check("rst_jogador", o_jogador, 0);
        check("rst_x", o_x, 0);
        check("rst_y", o_y, 0);
        check("rst_ready", o_ready, 0);
        check("rst_coord_err", o_coord_err, 0);
        check("rst_timeout_err", o_timeout_err, 0);

        // Player vs CPU: only player 0 places the fleet.
        for (int k = 0; k < FLEET_SZ; k++) begin
            if (k == 1) begin
                w0 = wr_seen;
                val_ack = 1'b1; tick(2); val_ack = 1'b0; tick(2);
                check("ack_outside_val_state", o_estado, 1);
                check("ack_outside_val_wr", wr_seen, w0);
            end
            if (k == 3) begin
                enable = 1'b0; press_enter(); enable = 1'b1; tick(2);
                check("enable_low_hold", o_estado, 1);
            end
            if (k == 0)
                place(k, 5, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
            else
                place(k, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 2),
                      (k == 1) ? 6 : $urandom_range(0, 6), k == 1, k == 2, k == 2, k == 3);
            if (k == 0) begin
                check("first_x", o_x, 3);
                check("first_y", o_y, 8);
            end
            if (k == 4) check("tipo_after_subs", o_tipo, 1);
            if (k < FLEET_SZ - 1) check("ready_low_mid", o_ready, 0);
        end
        check("mode0_ready", o_ready, 1);
        check("mode0_jogador", o_jogador, 0);
        check("mode0_done_estado", o_estado, 0);
        w0 = wr_seen;
        press_enter(); press_select();
        check("done_ignores_estado", o_estado, 0);
        check("done_ignores_wr", wr_seen, w0);

        // Two-player game: both players place the full fleet.
        reset = 1'b1; mode = 1'b1; tick(2);
        reset = 1'b0; tick(2);
        check("rst2_ready", o_ready, 0);
        check("rst2_estado", o_estado, 1);
        for (int k = 0; k < 2 * FLEET_SZ; k++) begin
            place(k, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 2),
                  $urandom_range(0, 6), 1'b0, 1'b0, 1'b0, 1'b0);
            if (k == FLEET_SZ - 1) begin
                check("mode1_ready_after_p0", o_ready, 0);
                check("mode1_jogador_p1", o_jogador, 1);
            end
        end
        check("mode1_ready", o_ready, 1);
        check("mode1_done_estado", o_estado, 0);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
